// File: rtl/sr_flag_arbiter.sv
// Round-robin sequencer sharing one SR status flop among NREQ requesters: IDLE -> ISSUE (S/R pulse) -> CHECK (done/gnt/err).
// Optional SR_OWNER_LOCK_EN: a clear of a set flag is rejected unless it comes from the last successful setter.
module sr_flag_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q,
  output logic            S,
  output logic            R,
  output logic [NREQ-1:0] gnt,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [IDXW-1:0] owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] win_idx_q, win_idx_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic            win_op_q, win_op_d;
  logic            rej_q, rej_d;
  logic            s_q, s_d, r_q, r_d;
  logic            done_q, done_d, busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic            found;
  logic [IDXW-1:0] pick;
  logic [IDXW:0]   cand;
  logic            pick_rej;

  // Rotating priority scan starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDXW-1:0];
      end
    end
  end

`ifdef SR_OWNER_LOCK_EN
  assign pick_rej = ~op[pick] & q & (pick != owner_q);
`else
  assign pick_rej = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (found) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_idx_d = win_idx_q;
    win_op_d  = win_op_q;
    rej_d     = rej_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    gnt_d     = '0;
    done_d    = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_idx_d = pick;
          win_op_d  = op[pick];
          rej_d     = pick_rej;
          s_d       = op[pick] & ~pick_rej;
          r_d       = ~op[pick] & ~pick_rej;
        end
      end
      ST_ISSUE: begin
        gnt_d[win_idx_q] = 1'b1;
        done_d           = 1'b1;
      end
      ST_CHECK: begin
        if (win_op_q & ~rej_q & q) owner_d = win_idx_q;
        rr_ptr_d = (win_idx_q == IDXW'(NREQ-1)) ? '0 : win_idx_q + IDXW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      win_op_q  <= 1'b0;
      rej_q     <= 1'b0;
      owner_q   <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      win_op_q  <= win_op_d;
      rej_q     <= rej_d;
      owner_q   <= owner_d;
      s_q       <= s_d;
      r_q       <= r_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign S     = s_q;
  assign R     = r_q;
  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  // The flop's Q only settles at the edge that opens CHECK, so err is qualified from live q.
  assign err   = done_q & (rej_q | (q != win_op_q));

endmodule
